// File: rtl/loader_pkg.sv
// Shared types and header layout for the CPU program loader.
package loader_pkg;

   typedef enum logic [1:0] {
      TGT_IMEM  = 2'd0,
      TGT_DMEM  = 2'd1,
      TGT_REG   = 2'd2,
      TGT_START = 2'd3
   } target_e;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_DATA = 2'd1,
      ST_CHK  = 2'd2,
      ST_RUN  = 2'd3
   } state_e;

   localparam int WORD_W       = 32;
   localparam int HDR_TGT_MSB  = 31;
   localparam int HDR_TGT_LSB  = 30;
   localparam int HDR_CNT_MSB  = 29;
   localparam int HDR_CNT_LSB  = 16;
   localparam int HDR_BASE_MSB = 15;
   localparam int HDR_BASE_LSB = 0;
   localparam int CNT_W        = HDR_CNT_MSB - HDR_CNT_LSB + 1;
   localparam int BASE_W       = HDR_BASE_MSB - HDR_BASE_LSB + 1;
   localparam int ADDR_SUM_W   = BASE_W + 1;
   localparam int REG_AW       = 5;
   localparam int REG_DEPTH    = 32;

endpackage

// File: rtl/loader_wr_port.sv
// Registered write strobe/address/data for one memory or register-file port.
module loader_wr_port
   import loader_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [WORD_W-1:0] i_data,
   output logic              o_we,
   output logic [AW-1:0]     o_addr,
   output logic [WORD_W-1:0] o_data
);

   logic              r_we;
   logic [AW-1:0]     r_addr;
   logic [WORD_W-1:0] r_data;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_we <= i_we;
         if (i_we) begin
            r_addr <= i_addr;
            r_data <= i_data;
         end
      end
   end

   assign o_we   = r_we;
   assign o_addr = r_addr;
   assign o_data = r_data;

endmodule

// File: rtl/cpu_program_loader.sv
// Framed word-stream loader filling IMEM, DMEM and the register file, then starting the CPU.
// Optional trailing XOR checksum per record when LOADER_CHECKSUM_EN is defined.
module cpu_program_loader
   import loader_pkg::*;
#(
   parameter int IMEM_AW = 8,
   parameter int DMEM_AW = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               in_valid_i,
   input  logic [WORD_W-1:0]  in_data_i,
   output logic               in_ready_o,
   output logic               imem_we_o,
   output logic [IMEM_AW-1:0] imem_addr_o,
   output logic [WORD_W-1:0]  imem_data_o,
   output logic               dmem_we_o,
   output logic [DMEM_AW-1:0] dmem_addr_o,
   output logic [WORD_W-1:0]  dmem_data_o,
   output logic               reg_we_o,
   output logic [REG_AW-1:0]  reg_addr_o,
   output logic [WORD_W-1:0]  reg_data_o,
   output logic               start_o,
   output logic               busy_o,
   output logic               err_o
);

   localparam logic [ADDR_SUM_W-1:0] IMEM_DEPTH = ADDR_SUM_W'(1 << IMEM_AW);
   localparam logic [ADDR_SUM_W-1:0] DMEM_DEPTH = ADDR_SUM_W'(1 << DMEM_AW);
   localparam logic [ADDR_SUM_W-1:0] RF_DEPTH   = ADDR_SUM_W'(REG_DEPTH);

   state_e              r_state;
   state_e              w_state_nxt;
   target_e             r_tgt;
   logic [BASE_W-1:0]   r_base;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_k;
   logic                r_ready;
   logic                r_busy;
   logic                r_start;
   logic                r_err;
`ifdef LOADER_CHECKSUM_EN
   logic [WORD_W-1:0]   r_xor;
`endif

   logic                  w_acc;
   target_e               w_hdr_tgt;
   logic [CNT_W-1:0]      w_hdr_cnt;
   logic [BASE_W-1:0]     w_hdr_base;
   logic [ADDR_SUM_W-1:0] w_addr;
   logic                  w_oob;
   logic                  w_last;
   logic                  w_imem_we;
   logic                  w_dmem_we;
   logic                  w_reg_we;
   logic                  w_err_set;
   logic                  w_hdr_load;
   logic                  w_data_step;

   assign w_acc      = in_valid_i & r_ready;
   assign w_hdr_tgt  = target_e'(in_data_i[HDR_TGT_MSB:HDR_TGT_LSB]);
   assign w_hdr_cnt  = in_data_i[HDR_CNT_MSB:HDR_CNT_LSB];
   assign w_hdr_base = in_data_i[HDR_BASE_MSB:HDR_BASE_LSB];
   assign w_addr     = {1'b0, r_base} + {{(ADDR_SUM_W-CNT_W){1'b0}}, r_k};
   assign w_last     = ({1'b0, r_k} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, r_cnt};

   // Addresses never wrap: anything past the target's depth is dropped and flagged.
   always_comb begin
      w_oob = 1'b0;
      case (r_tgt)
         TGT_IMEM: w_oob = (w_addr >= IMEM_DEPTH);
         TGT_DMEM: w_oob = (w_addr >= DMEM_DEPTH);
         TGT_REG:  w_oob = (w_addr >= RF_DEPTH);
         default:  w_oob = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_imem_we   = 1'b0;
      w_dmem_we   = 1'b0;
      w_reg_we    = 1'b0;
      w_err_set   = 1'b0;
      w_hdr_load  = 1'b0;
      w_data_step = 1'b0;
      case (r_state)
         ST_HDR: begin
            if (w_acc) begin
               if (w_hdr_tgt == TGT_START) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_hdr_load = 1'b1;
                  if (w_hdr_cnt != '0) begin
                     w_state_nxt = ST_DATA;
                  end else begin
`ifdef LOADER_CHECKSUM_EN
                     w_state_nxt = ST_CHK;
`else
                     w_state_nxt = ST_HDR;
`endif
                  end
               end
            end
         end
         ST_DATA: begin
            if (w_acc) begin
               w_data_step = 1'b1;
               if (w_oob) begin
                  w_err_set = 1'b1;
               end else begin
                  case (r_tgt)
                     TGT_IMEM: w_imem_we = 1'b1;
                     TGT_DMEM: w_dmem_we = 1'b1;
                     TGT_REG:  w_reg_we  = (w_addr[REG_AW-1:0] != '0);
                     default:  w_err_set = 1'b0;
                  endcase
               end
               if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                  w_state_nxt = ST_CHK;
`else
                  w_state_nxt = ST_HDR;
`endif
               end
            end
         end
         ST_CHK: begin
`ifdef LOADER_CHECKSUM_EN
            if (w_acc) begin
               w_err_set   = (in_data_i != r_xor);
               w_state_nxt = ST_HDR;
            end
`else
            w_state_nxt = ST_HDR;
`endif
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Status outputs are registered from the next state so they line up with the strobes.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_HDR;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_start <= 1'b0;
         r_err   <= 1'b0;
         r_tgt   <= TGT_IMEM;
         r_base  <= '0;
         r_cnt   <= '0;
         r_k     <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_xor   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt != ST_RUN);
         r_busy  <= (w_state_nxt == ST_DATA) || (w_state_nxt == ST_CHK);
         r_start <= (w_state_nxt == ST_RUN);
         r_err   <= r_err | w_err_set;
         if (w_hdr_load) begin
            r_tgt  <= w_hdr_tgt;
            r_base <= w_hdr_base;
            r_cnt  <= w_hdr_cnt;
            r_k    <= '0;
         end else if (w_data_step) begin
            r_k <= r_k + {{(CNT_W-1){1'b0}}, 1'b1};
         end
`ifdef LOADER_CHECKSUM_EN
         if (w_hdr_load) begin
            r_xor <= in_data_i;
         end else if (w_data_step) begin
            r_xor <= r_xor ^ in_data_i;
         end
`endif
      end
   end

   assign in_ready_o = r_ready;
   assign busy_o     = r_busy;
   assign start_o    = r_start;
   assign err_o      = r_err;

   loader_wr_port #(.AW(IMEM_AW)) u_imem_port (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_we   (w_imem_we),
      .i_addr (w_addr[IMEM_AW-1:0]),
      .i_data (in_data_i),
      .o_we   (imem_we_o),
      .o_addr (imem_addr_o),
      .o_data (imem_data_o)
   );

   loader_wr_port #(.AW(DMEM_AW)) u_dmem_port (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_we   (w_dmem_we),
      .i_addr (w_addr[DMEM_AW-1:0]),
      .i_data (in_data_i),
      .o_we   (dmem_we_o),
      .o_addr (dmem_addr_o),
      .o_data (dmem_data_o)
   );

   loader_wr_port #(.AW(REG_AW)) u_reg_port (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_we   (w_reg_we),
      .i_addr (w_addr[REG_AW-1:0]),
      .i_data (in_data_i),
      .o_we   (reg_we_o),
      .o_addr (reg_addr_o),
      .o_data (reg_data_o)
   );

endmodule

// File: tb/tb_cpu_program_loader.sv
// Table-driven directed bench for cpu_program_loader (default parameters).
module tb_cpu_program_loader;

   typedef struct {
      logic        vld;
      logic [31:0] data;
      logic        rdy;
      logic [1:0]  sel;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic        start;
      logic        busy;
      logic        err;
   } vec_t;

`ifdef LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic        imem_we, dmem_we, reg_we;
   logic [7:0]  imem_addr;
   logic [4:0]  dmem_addr, reg_addr;
   logic [31:0] imem_data, dmem_data, reg_data;
   logic        start, busy, err;

   int checks = 0;
   int errors = 0;
   vec_t tv[$];

   cpu_program_loader #(.IMEM_AW(8), .DMEM_AW(5)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready),
      .imem_we_o   (imem_we),
      .imem_addr_o (imem_addr),
      .imem_data_o (imem_data),
      .dmem_we_o   (dmem_we),
      .dmem_addr_o (dmem_addr),
      .dmem_data_o (dmem_data),
      .reg_we_o    (reg_we),
      .reg_addr_o  (reg_addr),
      .reg_data_o  (reg_data),
      .start_o     (start),
      .busy_o      (busy),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r,
                               input logic [1:0] s, input logic [15:0] a, input logic [31:0] wd,
                               input logic st, input logic bz, input logic er);
      vec_t t;
      t.vld = v; t.data = d; t.rdy = r; t.sel = s; t.addr = a; t.wdata = wd;
      t.start = st; t.busy = bz; t.err = er;
      return t;
   endfunction

   function automatic logic [54:0] pack_exp(input vec_t t);
      return {t.rdy, t.sel == 2'd1, t.sel == 2'd2, t.sel == 2'd3, t.addr, t.wdata,
              t.start, t.busy, t.err};
   endfunction

   function automatic logic [54:0] observe();
      logic [15:0] a;
      logic [31:0] d;
      a = '0;
      d = '0;
      if (imem_we) begin
         a = {8'd0, imem_addr}; d = imem_data;
      end else if (dmem_we) begin
         a = {11'd0, dmem_addr}; d = dmem_data;
      end else if (reg_we) begin
         a = {11'd0, reg_addr}; d = reg_data;
      end
      return {in_ready, imem_we, dmem_we, reg_we, a, d, start, busy, err};
   endfunction

   task automatic check(input string nm, input logic [54:0] got, input logic [54:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifndef LOADER_CHECKSUM_EN
      // IMEM load of three words at base 4
      tv.push_back(mk(1, 32'h0003_0004, 1, 0, 0, 0, 0, 1, 0));
      tv.push_back(mk(1, 32'h0050_0093, 1, 1, 4, 32'h0050_0093, 0, 1, 0));
      tv.push_back(mk(1, 32'h00A0_0113, 1, 1, 5, 32'h00A0_0113, 0, 1, 0));
      tv.push_back(mk(1, 32'h0020_81B3, 1, 1, 6, 32'h0020_81B3, 0, 0, 0));
      // DMEM load with idle gaps
      tv.push_back(mk(1, 32'h4001_0000, 1, 0, 0, 0, 0, 1, 0));
      tv.push_back(mk(0, 32'h0000_0005, 1, 0, 0, 0, 0, 1, 0));
      tv.push_back(mk(0, 32'h0000_0005, 1, 0, 0, 0, 0, 1, 0));
      tv.push_back(mk(1, 32'h0000_0005, 1, 2, 0, 32'h0000_0005, 0, 0, 0));
      tv.push_back(mk(0, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 0));
      // REG load: x0 suppressed silently, x1 written
      tv.push_back(mk(1, 32'h8002_0000, 1, 0, 0, 0, 0, 1, 0));
      tv.push_back(mk(1, 32'h0000_0007, 1, 0, 0, 0, 0, 1, 0));
      tv.push_back(mk(1, 32'h0000_0009, 1, 3, 1, 32'h0000_0009, 0, 0, 0));
      // DMEM overrun at base 31
      tv.push_back(mk(1, 32'h4002_001F, 1, 0, 0, 0, 0, 1, 0));
      tv.push_back(mk(1, 32'hAAAA_5555, 1, 2, 31, 32'hAAAA_5555, 0, 1, 0));
      tv.push_back(mk(1, 32'h1234_5678, 1, 0, 0, 0, 0, 0, 1));
      // count=0 header stays in HDR; loading continues after error
      tv.push_back(mk(1, 32'h0000_0010, 1, 0, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 32'h0001_0002, 1, 0, 0, 0, 0, 1, 1));
      tv.push_back(mk(1, 32'hDEAD_BEEF, 1, 1, 2, 32'hDEAD_BEEF, 0, 0, 1));
      // START, then further words are refused
      tv.push_back(mk(1, 32'hC000_0000, 0, 0, 0, 0, 1, 0, 1));
      tv.push_back(mk(1, 32'h0001_0000, 0, 0, 0, 0, 1, 0, 1));
      tv.push_back(mk(1, 32'h1111_1111, 0, 0, 0, 0, 1, 0, 1));
`else
      tv.push_back(mk(1, 32'h0002_0003, 1, 0, 0, 0, 0, 1, 0));
      tv.push_back(mk(1, 32'h1111_0000, 1, 1, 3, 32'h1111_0000, 0, 1, 0));
      tv.push_back(mk(1, 32'h0000_2222, 1, 1, 4, 32'h0000_2222, 0, 1, 0));
      tv.push_back(mk(1, 32'h1113_2221, 1, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 32'h0001_0000, 1, 0, 0, 0, 0, 1, 0));
      tv.push_back(mk(1, 32'h0000_0001, 1, 1, 0, 32'h0000_0001, 0, 1, 0));
      tv.push_back(mk(1, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 32'h4000_0000, 1, 0, 0, 0, 0, 1, 1));
      tv.push_back(mk(1, 32'h4000_0000, 1, 0, 0, 0, 0, 0, 1));
      tv.push_back(mk(1, 32'hC000_0000, 0, 0, 0, 0, 1, 0, 1));
      tv.push_back(mk(1, 32'h0001_0000, 0, 0, 0, 0, 1, 0, 1));
`endif

      // Reset state, during and after reset
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", observe(), pack_exp(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release", observe(), pack_exp(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)));

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].vld, tv[i].data);
         check($sformatf("vec%0d", i), observe(), pack_exp(tv[i]));
      end

      // Reset leaves RUN
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_from_run", observe(), pack_exp(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)));
      @(negedge clk);
      rst_n = 1'b1;

      // Reset asserted mid-record, one word into a three-word IMEM load
      drive(1, 32'h0003_0000);
      check("mid_hdr", observe(), pack_exp(mk(0, 0, 1, 0, 0, 0, 0, 1, 0)));
      drive(1, 32'h0000_0001);
      check("mid_word0", observe(), pack_exp(mk(0, 0, 1, 1, 0, 32'h1, 0, 1, 0)));
      @(negedge clk);
      in_data = 32'h0000_0002;
      rst_n = 1'b0;
      #1;
      check("mid_async_rst", observe(), pack_exp(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)));
      @(posedge clk);
      #1;
      check("mid_rst_hold", observe(), pack_exp(mk(0, 0, 1, 0, 0, 0, 0, 0, 0)));
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      drive(1, 32'h4001_0003);
      check("post_rst_hdr", observe(), pack_exp(mk(0, 0, 1, 0, 0, 0, 0, 1, 0)));
      drive(1, 32'h0000_0077);
      check("post_rst_data", observe(), pack_exp(mk(0, 0, 1, 2, 3, 32'h77, 0, CK, 0)));
      drive(0, 32'h0);
      check("post_rst_idle", observe(), pack_exp(mk(0, 0, 1, 0, 0, 0, 0, CK, 0)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
